countdown_timer: RTL and testbench



---
 rtl/countdown_timer.sv | 98 +++++++++
 tb/tb_countdown_timer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle expiry strobe and busy status.
// Optional periodic mode: define COUNTDOWN_TIMER_AUTORELOAD_EN to re-arm from the reload register.
module countdown_timer #(
  parameter int BIT_NUM = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               load_en,
  input  logic [BIT_NUM-1:0] load_val,
  input  logic               count_en,
  input  logic               abort,
  output logic [BIT_NUM-1:0] count_val,
  output logic               busy,
  output logic               done_flag
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    EXPIRE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BIT_NUM-1:0] count_q, count_d;
  logic [BIT_NUM-1:0] reload_q, reload_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    if (abort) begin
      state_d = IDLE;
      count_d = '0;
    end else if (load_en) begin
      reload_d = load_val;
      if (load_val != '0) begin
        state_d = RUN;
        count_d = load_val;
      end else begin
        state_d = EXPIRE;
        count_d = '0;
      end
    end else begin
      case (state_q)
        RUN: begin
          // RUN never holds zero, so reaching one is the only exit
          if (count_en) begin
            if (count_q == BIT_NUM'(1)) begin
              state_d = EXPIRE;
              count_d = '0;
            end else begin
              count_d = count_q - BIT_NUM'(1);
            end
          end
        end
        EXPIRE: begin
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
          if (reload_q != '0) begin
            state_d = RUN;
            count_d = reload_q;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
    // Status flags registered from the next state so they align with count_val
    busy_d = (state_d != IDLE);
    done_d = (state_d == EXPIRE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign count_val = count_q;
  assign busy      = busy_q;
  assign done_flag = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: randomized and directed stimulus vs. a behavioural model.
module tb_countdown_timer;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         load_en = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         count_en = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] count_val;
  logic         busy;
  logic         done_flag;

  countdown_timer #(.BIT_NUM(W)) dut (
    .CLK(CLK), .RST(RST), .load_en(load_en), .load_val(load_val),
    .count_en(count_en), .abort(abort), .count_val(count_val),
    .busy(busy), .done_flag(done_flag)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int cnt;
    bit bsy;
    bit dn;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Behavioural model: remaining events, whether counting, whether firing this cycle
  int m_rem = 0;
  int m_reload = 0;
  bit m_active = 0;
  bit m_fire = 0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  task automatic model_step(input bit ab, input bit ld, input int v, input bit en);
    if (ab) begin
      m_rem = 0; m_active = 0; m_fire = 0;
    end else if (ld) begin
      m_reload = v;
      m_rem = v;
      m_active = (v != 0);
      m_fire = (v == 0);
    end else if (m_fire) begin
      m_fire = 0;
      if (AUTO && m_reload != 0) begin
        m_active = 1;
        m_rem = m_reload;
      end else begin
        m_active = 0;
      end
    end else if (m_active && en) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_active = 0;
        m_fire = 1;
      end
    end
  endtask

  task automatic cyc(input bit ab, input bit ld, input int v, input bit en);
    exp_t e;
    @(negedge CLK);
    abort = ab; load_en = ld; load_val = W'(v); count_en = en;
    model_step(ab, ld, v, en);
    e.cnt = m_rem; e.bsy = m_active || m_fire; e.dn = m_fire;
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string name, input int cnt, input bit bsy, input bit dn);
    checks++;
    if (int'(count_val) != cnt || busy !== bsy || done_flag !== dn) begin
      failures++;
      $display("FAIL %s got cnt=%0d busy=%0b done=%0b exp cnt=%0d busy=%0b done=%0b",
               name, count_val, busy, done_flag, cnt, bsy, dn);
    end
  endtask

  // Monitor: every edge the DUT presents a new registered output
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_now("scoreboard", e.cnt, e.bsy, e.dn);
      end
    end
  end

  initial begin
    #1;
    check_now("reset_state", 0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // One-shot load 3
    cyc(0, 1, 3, 1);
    repeat (5) cyc(0, 0, 0, 1);
    // Gating: load 2 then en 1,0,1
    cyc(0, 1, 2, 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 0); cyc(0, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 1);
    // Zero load
    cyc(0, 1, 0, 1);
    repeat (2) cyc(0, 0, 0, 1);
    // Load and abort together
    cyc(1, 1, 7, 1);
    repeat (2) cyc(0, 0, 0, 1);
    // Reload mid-count
    cyc(0, 1, 4, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    cyc(0, 1, 4, 1);
    repeat (6) cyc(0, 0, 0, 1);
    // Load 1 while in EXPIRE
    cyc(0, 1, 1, 1); cyc(0, 0, 0, 1);
    cyc(0, 1, 1, 0);
    repeat (3) cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    // Boundary: load max value, expires after 16 edges without wrapping
    cyc(0, 1, 15, 1);
    repeat (15) cyc(0, 0, 0, 1);
    @(posedge CLK); #2;
    check_now("boundary_15", 0, 1'b1, 1'b1);
    repeat (3) cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    // Periodic behaviour (one-shot build simply goes idle)
    cyc(0, 1, 2, 1);
    repeat (9) cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
          int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
    end

    // Asynchronous reset mid-RUN at count 5
    cyc(0, 1, 8, 1);
    repeat (3) cyc(0, 0, 0, 1);
    @(posedge CLK); #2;
    check_now("pre_reset_5", 5, 1'b1, 1'b0);
    @(negedge CLK);
    count_en = 1'b1; load_en = 1'b0; abort = 1'b0;
    #2 RST = 1'b1;
    #1;
    check_now("async_reset", 0, 1'b0, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    m_rem = 0; m_reload = 0; m_active = 0; m_fire = 0;
    repeat (3) cyc(0, 0, 0, 1);

    repeat (3) @(posedge CLK);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
